// File: rtl/wb_spram_arbiter.sv
// Shares one single-port 32-bit RAM between two pipelined Wishbone slave ports.
// Round-robin with bounded burst hold (or fixed p0 priority); every access acks one cycle after issue.
module wb_spram_arbiter #(
   parameter int ADDR_WIDTH = 9,
   parameter int MAX_BURST  = 4,
   parameter int ARB_MODE   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  p0_cyc,
   input  logic                  p0_stb,
   input  logic                  p0_we,
   input  logic [3:0]            p0_sel,
   input  logic [ADDR_WIDTH-1:0] p0_adr,
   input  logic [31:0]           p0_dat_i,
   output logic [31:0]           p0_dat_o,
   output logic                  p0_ack,
   output logic                  p0_stall,
   input  logic                  p1_cyc,
   input  logic                  p1_stb,
   input  logic                  p1_we,
   input  logic [3:0]            p1_sel,
   input  logic [ADDR_WIDTH-1:0] p1_adr,
   input  logic [31:0]           p1_dat_i,
   output logic [31:0]           p1_dat_o,
   output logic                  p1_ack,
   output logic                  p1_stall,
   output logic [ADDR_WIDTH-3:0] ram_addr,
   output logic                  ram_ce,
   output logic [3:0]            ram_we,
   output logic [31:0]           ram_d,
   input  logic [31:0]           ram_q
);
   localparam int CW = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} owner_t;

   owner_t        owner_q;
   logic [CW-1:0] cnt_q;
   logic          last_q;
   logic          ack0_q;
   logic          ack1_q;

   logic          req0;
   logic          req1;
   logic          grant0;
   logic          grant1;
   logic          hold_done;
   logic [CW-1:0] cnt_inc;

   assign req0      = p0_cyc & p0_stb;
   assign req1      = p1_cyc & p1_stb;
   assign hold_done = (cnt_q == CNT_MAX);
   assign cnt_inc   = hold_done ? cnt_q : cnt_q + CNT_ONE;

   // No grant is ever issued while rst is high, so a reset cycle never touches the RAM.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!rst) begin
         if (req0 && req1) begin
            if (ARB_MODE == 0) begin
               grant0 = 1'b1;
            end else begin
               case (owner_q)
                  OWN0: begin
                     grant0 = !hold_done;
                     grant1 = hold_done;
                  end
                  OWN1: begin
                     grant1 = !hold_done;
                     grant0 = hold_done;
                  end
                  default: begin
                     grant0 = last_q;
                     grant1 = !last_q;
                  end
               endcase
            end
         end else begin
            grant0 = req0;
            grant1 = req1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q <= IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
      end else begin
         ack0_q <= grant0;
         ack1_q <= grant1;
         if (grant0) begin
            owner_q <= OWN0;
            last_q  <= 1'b0;
            cnt_q   <= (owner_q == OWN0) ? cnt_inc : CNT_ONE;
         end else if (grant1) begin
            owner_q <= OWN1;
            last_q  <= 1'b1;
            cnt_q   <= (owner_q == OWN1) ? cnt_inc : CNT_ONE;
         end else begin
            owner_q <= IDLE;
            cnt_q   <= '0;
         end
      end
   end

   assign ram_ce   = grant0 | grant1;
   assign ram_addr = grant1 ? p1_adr[ADDR_WIDTH-1:2] : p0_adr[ADDR_WIDTH-1:2];
   assign ram_we   = grant1 ? (p1_sel & {4{p1_we}}) :
                     grant0 ? (p0_sel & {4{p0_we}}) : 4'b0000;
   assign ram_d    = grant1 ? p1_dat_i : p0_dat_i;

   assign p0_stall = !grant0;
   assign p1_stall = !grant1;
   assign p0_ack   = ack0_q & p0_cyc;
   assign p1_ack   = ack1_q & p1_cyc;
   assign p0_dat_o = ram_q;
   assign p1_dat_o = ram_q;

   // Byte-lane bits of the address never reach the word-addressed RAM.
   logic unused_adr_lsbs;
   assign unused_adr_lsbs = ^{p0_adr[1:0], p1_adr[1:0]};
endmodule

// File: tb/tb_wb_spram_arbiter.sv
// Bench for wb_spram_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model (grant rules, reference memory, pending acks).
module tb_wb_spram_arbiter;
   localparam int AW    = 9;
   localparam int MAXB  = 4;
   localparam int WORDS = 1 << (AW - 2);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, mem_init;
   logic          p0_cyc, p0_stb, p0_we, p0_ack, p0_stall;
   logic [3:0]    p0_sel;
   logic [AW-1:0] p0_adr;
   logic [31:0]   p0_dat_i, p0_dat_o;
   logic          p1_cyc, p1_stb, p1_we, p1_ack, p1_stall;
   logic [3:0]    p1_sel;
   logic [AW-1:0] p1_adr;
   logic [31:0]   p1_dat_i, p1_dat_o;
   logic [AW-3:0] ram_addr, f_ram_addr;
   logic          ram_ce, f_ram_ce;
   logic [3:0]    ram_we, f_ram_we;
   logic [31:0]   ram_d, f_ram_d, ram_q, f_dat0, f_dat1;
   logic          f_ack0, f_ack1, f_stall0, f_stall1;

   wb_spram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MAXB), .ARB_MODE(1)) dut (
      .clk(clk), .rst(rst),
      .p0_cyc(p0_cyc), .p0_stb(p0_stb), .p0_we(p0_we), .p0_sel(p0_sel), .p0_adr(p0_adr),
      .p0_dat_i(p0_dat_i), .p0_dat_o(p0_dat_o), .p0_ack(p0_ack), .p0_stall(p0_stall),
      .p1_cyc(p1_cyc), .p1_stb(p1_stb), .p1_we(p1_we), .p1_sel(p1_sel), .p1_adr(p1_adr),
      .p1_dat_i(p1_dat_i), .p1_dat_o(p1_dat_o), .p1_ack(p1_ack), .p1_stall(p1_stall),
      .ram_addr(ram_addr), .ram_ce(ram_ce), .ram_we(ram_we), .ram_d(ram_d), .ram_q(ram_q));

   wb_spram_arbiter #(.ADDR_WIDTH(AW), .MAX_BURST(MAXB), .ARB_MODE(0)) dut_fp (
      .clk(clk), .rst(rst),
      .p0_cyc(p0_cyc), .p0_stb(p0_stb), .p0_we(p0_we), .p0_sel(p0_sel), .p0_adr(p0_adr),
      .p0_dat_i(p0_dat_i), .p0_dat_o(f_dat0), .p0_ack(f_ack0), .p0_stall(f_stall0),
      .p1_cyc(p1_cyc), .p1_stb(p1_stb), .p1_we(p1_we), .p1_sel(p1_sel), .p1_adr(p1_adr),
      .p1_dat_i(p1_dat_i), .p1_dat_o(f_dat1), .p1_ack(f_ack1), .p1_stall(f_stall1),
      .ram_addr(f_ram_addr), .ram_ce(f_ram_ce), .ram_we(f_ram_we), .ram_d(f_ram_d), .ram_q(ram_q));

   function automatic logic [31:0] seed_word(int i);
      return (32'h9E37_79B9 * 32'(i)) ^ 32'h5A5A_1234;
   endfunction

   // Single-port RAM: registered read, byte write enables.
   logic [31:0] ram_mem [WORDS];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < WORDS; i++) ram_mem[i] <= seed_word(i);
      end else if (ram_ce) begin
         ram_q <= ram_mem[ram_addr];
         for (int b = 0; b < 4; b++)
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_d[8*b +: 8];
      end
   end

   // Reference model state: -1 = idle / no grant.
   int          m_owner, m_cnt, m_last, last_g, s_g;
   bit          pend [2];
   bit          pend_rd [2];
   logic [31:0] exp_rd [2];
   logic [31:0] ref_mem [WORDS];
   logic        s_ce, s_stall1, s_ack0, s_ack1, s_f_stall1, s_f_ack0, s_f_ack1;
   logic [3:0]  s_we;
   logic [AW-3:0] s_addr;
   logic [31:0] s_dat0, s_dat1;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] port_adr(int p); return (p == 0) ? p0_adr : p1_adr; endfunction
   function automatic logic port_we(int p); return (p == 0) ? p0_we : p1_we; endfunction
   function automatic logic [3:0] port_sel(int p); return (p == 0) ? p0_sel : p1_sel; endfunction
   function automatic logic [31:0] port_dat(int p); return (p == 0) ? p0_dat_i : p1_dat_i; endfunction
   function automatic logic port_req(int p);
      return (p == 0) ? (p0_cyc & p0_stb) : (p1_cyc & p1_stb);
   endfunction

   function automatic int model_grant();
      logic r0, r1;
      r0 = port_req(0);
      r1 = port_req(1);
      if (rst || (!r0 && !r1)) return -1;
      if (r0 != r1) return r0 ? 0 : 1;
      if (m_owner < 0) return (m_last == 1) ? 0 : 1;
      return (m_cnt < MAXB) ? m_owner : 1 - m_owner;
   endfunction

   task automatic commit(int g);
      int          w;
      logic [31:0] d;
      logic [3:0]  sel;
      pend[0] = (g == 0);
      pend[1] = (g == 1);
      if (rst) begin
         m_owner = -1; m_cnt = 0; m_last = 1;
      end else if (g < 0) begin
         m_owner = -1; m_cnt = 0;
      end else begin
         m_cnt   = (m_owner == g) ? ((m_cnt < MAXB) ? m_cnt + 1 : MAXB) : 1;
         m_owner = g;
         m_last  = g;
         w   = int'(port_adr(g) >> 2);
         d   = port_dat(g);
         sel = port_sel(g);
         pend_rd[g] = !port_we(g);
         if (port_we(g)) begin
            for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
         end else begin
            exp_rd[g] = ref_mem[w];
         end
         $display("txn t=%0t p%0d %s word=%0d sel=%h data=%h", $time, g,
                  port_we(g) ? "WR" : "RD", w, sel, port_we(g) ? d : exp_rd[g]);
      end
      last_g = g;
   endtask

   // Called at posedge+1 with inputs already set; checks at the falling edge, commits at the next posedge.
   task automatic tick();
      int g;
      g = model_grant();
      #4;
      s_g = !p0_stall ? 0 : (!p1_stall ? 1 : -1);
      s_ce = ram_ce; s_addr = ram_addr; s_we = ram_we; s_stall1 = p1_stall;
      s_ack0 = p0_ack; s_ack1 = p1_ack; s_dat0 = p0_dat_o; s_dat1 = p1_dat_o;
      s_f_stall1 = f_stall1; s_f_ack0 = f_ack0; s_f_ack1 = f_ack1;
      chk("p0_stall", 32'(p0_stall), 32'(g != 0));
      chk("p1_stall", 32'(p1_stall), 32'(g != 1));
      chk("ram_ce", 32'(ram_ce), 32'(g >= 0));
      if (g >= 0) begin
         chk("ram_addr", 32'(ram_addr), 32'(port_adr(g) >> 2));
         chk("ram_we", 32'(ram_we), 32'(port_we(g) ? port_sel(g) : 4'b0000));
         if (port_we(g)) chk("ram_d", ram_d, port_dat(g));
      end else begin
         chk("ram_we_idle", 32'(ram_we), 32'(0));
      end
      chk("p0_ack", 32'(p0_ack), 32'(pend[0] && p0_cyc));
      chk("p1_ack", 32'(p1_ack), 32'(pend[1] && p1_cyc));
      chk("acks_exclusive", 32'(p0_ack & p1_ack), 32'(0));
      if (pend[0] && p0_cyc && pend_rd[0]) chk("p0_dat_o", p0_dat_o, exp_rd[0]);
      if (pend[1] && p1_cyc && pend_rd[1]) chk("p1_dat_o", p1_dat_o, exp_rd[1]);
      @(posedge clk);
      #1;
      commit(g);
   endtask

   task automatic set_port(int p, logic cyc, logic stb, logic we, logic [3:0] sel,
                           logic [AW-1:0] adr, logic [31:0] dat);
      if (p == 0) begin
         p0_cyc = cyc; p0_stb = stb; p0_we = we; p0_sel = sel; p0_adr = adr; p0_dat_i = dat;
      end else begin
         p1_cyc = cyc; p1_stb = stb; p1_we = we; p1_sel = sel; p1_adr = adr; p1_dat_i = dat;
      end
   endtask

   task automatic rd(int p, logic [AW-1:0] adr);
      set_port(p, 1'b1, 1'b1, 1'b0, 4'hF, adr, 32'h0);
   endtask
   task automatic wr(int p, logic [AW-1:0] adr, logic [3:0] sel, logic [31:0] dat);
      set_port(p, 1'b1, 1'b1, 1'b1, sel, adr, dat);
   endtask
   task automatic wait_ack(int p);
      set_port(p, 1'b1, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
   endtask
   task automatic off(int p);
      set_port(p, 1'b0, 1'b0, 1'b0, 4'h0, 9'h000, 32'h0);
   endtask
   task automatic do_reset();
      rst = 1'b1;
      off(0);
      off(1);
      tick();
      rst = 1'b0;
   endtask

   int exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

   initial begin
      for (int i = 0; i < WORDS; i++) ref_mem[i] = seed_word(i);
      m_owner = -1; m_cnt = 0; m_last = 1; last_g = -1;
      pend[0] = 0; pend[1] = 0; pend_rd[0] = 0; pend_rd[1] = 0;
      rst = 1'b1; mem_init = 1'b1;
      off(0);
      off(1);
      @(posedge clk);
      #1;
      do_reset();
      mem_init = 1'b0;
      chk("reset_ack0", 32'(s_ack0), 32'(0));
      chk("reset_ack1", 32'(s_ack1), 32'(0));
      chk("reset_ce", 32'(s_ce), 32'(0));

      // Read after write of 0xDEADBEEF into word 4.
      wr(1, 9'h010, 4'hF, 32'hDEAD_BEEF); tick();
      off(1); rd(0, 9'h010); tick();
      chk("t1_ce", 32'(s_ce), 32'(1));
      chk("t1_addr", 32'(s_addr), 32'(4));
      chk("t1_grant", 32'(s_g), 32'(0));
      wait_ack(0); tick();
      chk("t1_ack", 32'(s_ack0), 32'(1));
      chk("t1_data", s_dat0, 32'hDEAD_BEEF);
      off(0);

      // Byte-masked write then readback.
      wr(1, 9'h008, 4'hF, 32'h1122_3344); tick();
      wr(1, 9'h008, 4'b0101, 32'hAABB_CCDD); tick();
      chk("t2_we", 32'(s_we), 32'(4'b0101));
      rd(1, 9'h008); tick();
      wait_ack(1); tick();
      chk("t2_ack", 32'(s_ack1), 32'(1));
      chk("t2_data", s_dat1, 32'h11BB_33DD);

      // Burst hold: p0 continuous, p1 single-beat requests.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         rd(0, 9'h020);
         if (c == 0 || c == 5) wait_ack(1); else rd(1, 9'h044);
         tick();
         chk("t3_grant", 32'(s_g), 32'(exp_seq[c]));
         if (c >= 1 && c <= 3) chk("t3_p1_stall", 32'(s_stall1), 32'(1));
         if (c == 1) chk("t3_p0_ack", 32'(s_ack0), 32'(1));
         if (c == 5) chk("t3_p1_ack", 32'(s_ack1), 32'(1));
      end

      // Tie after reset goes to p0; tie after idle with last=0 goes to p1.
      do_reset();
      rd(0, 9'h004); rd(1, 9'h00C); tick();
      chk("t5_first_tie", 32'(s_g), 32'(0));
      wait_ack(0); wait_ack(1); tick();
      rd(0, 9'h004); rd(1, 9'h00C); tick();
      chk("t5_second_tie", 32'(s_g), 32'(1));

      // Reset in the middle of a p1 burst; cyc drop suppresses an ack.
      do_reset();
      rd(1, 9'h030); tick(); tick();
      rst = 1'b1; tick();
      chk("t6_rst_ce", 32'(s_ce), 32'(0));
      rst = 1'b0; rd(0, 9'h014); rd(1, 9'h030); tick();
      chk("t6_no_ack1", 32'(s_ack1), 32'(0));
      chk("t6_idle_tie", 32'(s_g), 32'(0));
      off(0); tick();
      chk("t6_cyc_drop", 32'(s_ack0), 32'(0));
      off(1); tick();

      // Fixed-priority instance under continuous contention.
      do_reset();
      rd(0, 9'h018); rd(1, 9'h01C);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk("t4_fp_p1_stall", 32'(s_f_stall1), 32'(1));
         if (k >= 1) begin
            chk("t4_fp_p0_ack", 32'(s_f_ack0), 32'(1));
            chk("t4_fp_p1_ack", 32'(s_f_ack1), 32'(0));
         end
      end

      // Random traffic; a stalled request is held until granted.
      do_reset();
      for (int n = 0; n < 800; n++) begin
         for (int p = 0; p < 2; p++) begin
            if (!(port_req(p) && last_g != p))
               set_port(p, $urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0,
                        1'($urandom_range(0, 1)), 4'($urandom), 9'($urandom), $urandom);
         end
         rst = ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
